// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush/halt controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  localparam logic [3:0] OPC_HLT = 4'hF;
  localparam int DRAIN_CYCLES_DEF = 4;
  localparam logic [3:0] REG_ZERO = 4'h0;
endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// hazard_unit: combinational load-use compare between execute destination and decode sources.
module hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] i_rs,
  input  logic [3:0] i_rt,
  input  logic       i_uses_rt,
  input  logic       i_memread,
  input  logic [3:0] i_rd,
  output logic       o_hazard
);
  assign o_hazard = i_memread && (i_rd != REG_ZERO) && ((i_rd == i_rs) || (i_uses_rt && (i_rd == i_rt)));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt controller for the five-stage pipeline with a saturating stall counter.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_halt,
  input  logic [3:0]  fd_rs,
  input  logic [3:0]  fd_rt,
  input  logic        fd_uses_rt,
  input  logic        dx_memread,
  input  logic [3:0]  dx_rd,
  input  logic        branch_taken,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  output logic        pc_wen,
  output logic        fd_wen,
  output logic        dx_wen,
  output logic        xm_wen,
  output logic        mw_wen,
  output logic        fd_flush,
  output logic        dx_flush,
  output logic        halted,
  output logic [15:0] stall_cycles
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_stall;
  logic            r_halted;
  logic            w_load_use;
  logic            w_stall;
  hazard_unit u_hazard (
    .i_rs      (fd_rs),
    .i_rt      (fd_rt),
    .i_uses_rt (fd_uses_rt),
    .i_memread (dx_memread),
    .i_rd      (dx_rd),
    .o_hazard  (w_load_use)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= RUN;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     if (!dmem_busy && !w_load_use && !branch_taken && !imem_busy && if_halt) w_next = DRAIN;
      DRAIN:   if (!dmem_busy && r_cnt == '0) w_next = HALTED;
      default: w_next = HALTED;
    endcase
  end
  always_comb begin
    {pc_wen, fd_wen, dx_wen, xm_wen, mw_wen} = '1;
    {fd_flush, dx_flush} = '0;
    case (r_state)
      RUN:
        if (dmem_busy) {pc_wen, fd_wen, dx_wen, xm_wen, mw_wen} = '0;
        else if (w_load_use) {pc_wen, fd_wen, dx_flush} = 3'b001;
        else if (branch_taken) fd_flush = 1'b1;
        else if (imem_busy) {pc_wen, fd_flush} = 2'b01;
        else if (if_halt) pc_wen = 1'b0;
      DRAIN: begin
        {pc_wen, fd_flush} = 2'b01;
        if (dmem_busy) {fd_wen, dx_wen, xm_wen, mw_wen} = '0;
      end
      default: {pc_wen, fd_wen, dx_wen, xm_wen, mw_wen} = '0;
    endcase
  end
  // a taken branch suppresses the imem stall, so only rules 1, 2 and 4 count
  assign w_stall = (r_state == RUN) && (dmem_busy || w_load_use || (!branch_taken && imem_busy));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt    <= '0;
      r_stall  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_halted <= (r_state == HALTED);
      if (w_stall && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
      if (r_state == RUN && w_next == DRAIN) r_cnt <= CW'(DRAIN_CYCLES - 1);
      else if (r_state == DRAIN && !dmem_busy && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  assign halted = r_halted;
  assign stall_cycles = r_stall;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench; the driver queues hand-computed expectations, the monitor compares them.
module tb_pipeline_ctrl;
  typedef struct {
    logic [6:0]  ctrl;
    logic        h;
    logic [15:0] sc;
  } exp_t;
  localparam logic [6:0] ALL = 7'b1111100;
  localparam logic [6:0] LU  = 7'b0011101;
  localparam logic [6:0] BR  = 7'b1111110;
  localparam logic [6:0] IB  = 7'b0111110;
  localparam logic [6:0] FRZ = 7'b0000000;
  localparam logic [6:0] HL  = 7'b0111100;
  localparam logic [6:0] DR  = 7'b0111110;
  localparam logic [6:0] DRB = 7'b0000010;
  logic clk = 1'b0, rst = 1'b1;
  logic if_halt = 0, fd_uses_rt = 0, dx_memread = 0, branch_taken = 0, imem_busy = 0, dmem_busy = 0;
  logic [3:0] fd_rs = 0, fd_rt = 0, dx_rd = 0;
  logic pc_wen, fd_wen, dx_wen, xm_wen, mw_wen, fd_flush, dx_flush, halted;
  logic [15:0] stall_cycles;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  pipeline_ctrl dut (
    .clk(clk), .rst(rst), .if_halt(if_halt), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rt(fd_uses_rt),
    .dx_memread(dx_memread), .dx_rd(dx_rd), .branch_taken(branch_taken), .imem_busy(imem_busy),
    .dmem_busy(dmem_busy), .pc_wen(pc_wen), .fd_wen(fd_wen), .dx_wen(dx_wen), .xm_wen(xm_wen),
    .mw_wen(mw_wen), .fd_flush(fd_flush), .dx_flush(dx_flush), .halted(halted), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s @%0t act=%h req=%h", nm, $time, act, req);
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("ctrl", {9'd0, pc_wen, fd_wen, dx_wen, xm_wen, mw_wen, fd_flush, dx_flush}, {9'd0, e.ctrl});
      check("halted", {15'd0, halted}, {15'd0, e.h});
      check("stall_cycles", stall_cycles, e.sc);
    end
  end
  task automatic cyc(input logic r, ih, input logic [3:0] rs, rt, input logic urt, mr, input logic [3:0] rd,
                     input logic bt, ib, db, input logic [6:0] c, input logic h, input logic [15:0] s);
    exp_t e;
    @(negedge clk);
    rst = r; if_halt = ih; fd_rs = rs; fd_rt = rt; fd_uses_rt = urt; dx_memread = mr; dx_rd = rd;
    branch_taken = bt; imem_busy = ib; dmem_busy = db;
    e.ctrl = c; e.h = h; e.sc = s;
    q.push_back(e);
  endtask
  task automatic idle(input logic r, input logic [6:0] c, input logic h, input logic [15:0] s);
    cyc(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, c, h, s);
  endtask
  initial begin
    idle(1, ALL, 0, 0);
    cyc(0, 0, 3, 0, 0, 1, 3, 0, 0, 0, LU, 0, 0);
    idle(0, ALL, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ALL, 0, 1);
    idle(0, ALL, 0, 1);
    cyc(0, 0, 3, 0, 0, 1, 3, 1, 0, 0, LU, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, IB, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FRZ, 0, 3);
    cyc(0, 0, 3, 0, 0, 1, 3, 0, 1, 1, FRZ, 0, 4);
    cyc(0, 0, 1, 5, 1, 1, 5, 0, 0, 0, LU, 0, 5);
    cyc(0, 0, 1, 5, 0, 1, 5, 0, 0, 0, ALL, 0, 6);
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, BR, 0, 6);
    idle(0, ALL, 0, 6);
    cyc(0, 1, 3, 0, 0, 1, 3, 0, 0, 0, LU, 0, 6);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, HL, 0, 7);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, DR, 0, 7);
    cyc(0, 0, 3, 0, 0, 1, 3, 1, 0, 0, DR, 0, 7);
    idle(0, DR, 0, 7);
    idle(0, DR, 0, 7);
    idle(0, FRZ, 0, 7);
    idle(0, FRZ, 1, 7);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 7);
    idle(1, ALL, 0, 0);
    idle(0, ALL, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, HL, 0, 0);
    idle(0, DR, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DRB, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DRB, 0, 0);
    idle(0, DR, 0, 0);
    idle(0, DR, 0, 0);
    idle(0, DR, 0, 0);
    idle(0, FRZ, 0, 0);
    idle(0, FRZ, 1, 0);
    idle(1, ALL, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, HL, 0, 0);
    idle(0, DR, 0, 0);
    idle(1, ALL, 0, 0);
    idle(0, ALL, 0, 0);
    for (int k = 0; k < 65540; k++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, IB, 0, (k > 65535) ? 16'hFFFF : 16'(k));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 0, 16'hFFFF);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, IB, 0, 0);
    idle(0, ALL, 0, 0);
    @(negedge clk);
    #5;
    check("queue_drained", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush/halt controller for the 16-bit five-stage CPU pipeline. It drives the write-enable and flush controls of the PC and the F/D, D/X, X/M and M/W pipeline register banks. It resolves load-use hazards, taken branches (resolved in decode), multi-cycle instruction and data memory stalls, and halt draining. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- DRAIN_CYCLES, 4: number of cycles, after HLT enters F/D, until the pipeline is empty (HLT reaches M/W).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_halt  in  1  fetched instruction opcode equals 4'hF. Ignored while imem_busy=1.
- fd_rs  in  4  first source register of the instruction in decode.
- fd_rt  in  4  second source register of the instruction in decode.
- fd_uses_rt  in  1  the decode instruction reads fd_rt.
- dx_memread  in  1  the instruction in execute is a load.
- dx_rd  in  4  destination register of the instruction in execute.
- branch_taken  in  1  decode resolved a taken branch this cycle.
- imem_busy  in  1  instruction memory has not returned the fetch.
- dmem_busy  in  1  data memory access in the memory stage is not complete.
- pc_wen  out  1  PC update enable.
- fd_wen, dx_wen, xm_wen, mw_wen  out  1 each  pipeline bank write enables.
- fd_flush, dx_flush  out  1 each  load a bubble (NOP) into F/D or D/X on this edge.
- halted  out  1  pipeline fully drained after HLT.
- stall_cycles  out  16  count of stall cycles, saturating.

## Operation
- States: RUN, DRAIN, HALTED.
- load_use = dx_memread & (dx_rd != 0) & ((dx_rd == fd_rs) | (fd_uses_rt & (dx_rd == fd_rt))). R0 never hazards.
- RUN control uses the following priority (first match wins). All enables are 1 and all flushes are 0 unless listed.
  1. dmem_busy: all five wen = 0. The whole pipe freezes.
  2. load_use: pc_wen = 0, fd_wen = 0, dx_flush = 1. branch_taken is ignored because decode re-evaluates it next cycle.
  3. branch_taken: fd_flush = 1, which squashes the wrong-path fetch. The PC loads the target.
  4. imem_busy: pc_wen = 0, fd_flush = 1, so a bubble enters decode.
  5. if_halt: pc_wen = 0. HLT is latched into F/D. The state moves to DRAIN with drain_cnt = DRAIN_CYCLES-1.
- DRAIN:
  - pc_wen = 0 and fd_flush = 1 every cycle.
  - D/X, X/M and M/W advance unless dmem_busy=1, in which case all wen = 0.
  - drain_cnt decrements only on cycles with dmem_busy=0. At 0, the next state is HALTED.
  - load_use, branch_taken, imem_busy and if_halt are ignored in DRAIN.
- HALTED:
  - All wen = 0 and all flushes = 0.
  - halted = 1.
  - The controller stays in HALTED until rst.
- stall_cycles:
  - Increments on every RUN cycle where rule 1, 2 or 4 applies.
  - DRAIN and HALTED cycles are not counted.
  - Saturates at 16'hFFFF.
- Simultaneous if_halt and branch_taken: the branch wins, HLT is squashed, and the state stays RUN.
- Simultaneous if_halt and load_use: the stall wins, and HLT is re-presented next cycle.

## Timing
- Control outputs (wen, flush) are combinational from state plus the current inputs, and take effect on the same rising edge.
- halted and stall_cycles are registered outputs.
- Reset:
  - Asynchronous entry to RUN.
  - drain_cnt = 0, stall_cycles = 0, halted = 0.
  - While rst is high, the combinational outputs follow the RUN decode.
- Reset mid-DRAIN or in HALTED returns to RUN immediately, with no edge required.
- Halt latency: with no memory stalls, halted rises DRAIN_CYCLES+1 edges after the edge that latches HLT into F/D. Each dmem_busy cycle in DRAIN adds one cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum {RUN, DRAIN, HALTED};
  - OPC_HLT = 4'hF;
  - the default DRAIN_CYCLES;
  - REG_ZERO = 4'h0.
- Sub-module hazard_unit is the combinational load_use compare. It is reused later for forwarding checks.
- The top module contains the FSM, the drain counter, the priority decode and the stall counter.

## Test plan
- Load-use: dx_memread=1, dx_rd=3, fd_rs=3 for 1 cycle -> pc_wen=0, fd_wen=0, dx_flush=1, and stall_cycles goes 0 -> 1. The same case with dx_rd=0 -> no stall.
- Branch vs. load-use: branch_taken=1 with load_use=1 -> dx_flush=1 and fd_flush=0. Next cycle, branch_taken=1 alone -> fd_flush=1, pc_wen=1.
- Halt drain: if_halt=1 at edge N, all other inputs 0, DRAIN_CYCLES=4 -> pc_wen=0 from edge N, fd_flush=1 in each DRAIN cycle, halted=1 after edge N+5, all wen=0 afterwards.
- Halt with memory stall: the same as the halt-drain case, plus dmem_busy=1 for 2 cycles during DRAIN -> halted rises 2 cycles later, and all wen=0 during the busy cycles.
- Halt vs. branch: if_halt=1 and branch_taken=1 in the same cycle -> state stays RUN, fd_flush=1, halted never rises.
- Saturation and reset: hold imem_busy=1 for 70000 cycles -> stall_cycles=16'hFFFF. Assert rst asynchronously mid-cycle, including from DRAIN -> stall_cycles=0, halted=0, and the state is RUN immediately.
